motor_slot_scheduler: RTL and testbench



---
 rtl/motor_slot_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_motor_slot_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : motor_slot_scheduler
// Description : Time-slot scheduler that shares one speed-control datapath
//               among four motors. Requesters are picked round-robin. Each
//               winner gets a fixed RUN slot. During the slot the speed word
//               V ramps toward that motor's target by one LSB every RAMP_DIV
//               cycles. Each motor's last speed is kept between slots, so a
//               ramp resumes where it stopped.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SLOT_CYCLES : RUN-state length in cycles per grant (2..255)
//   RAMP_DIV    : cycles per one-LSB ramp step (1..SLOT_CYCLES)
// Ports
//   clk      in   1  system clock, rising edge
//   rst      in   1  asynchronous active-high reset
//   req      in   4  req[m]=1: motor m wants datapath time
//   vel_alvo in  16  targets, bits [4m+3:4m] belong to motor m (live)
//   S        out  2  motor select to the speed datapath
//   V        out  4  speed word to the speed datapath
//   grant    out  4  one-hot current owner, 0 when idle/ending
//   ocupado  out  1  high in GRANT, RUN and END
//   fim_slot out  1  one-cycle pulse in END
// Build option
//   MOTOR_SOFTSTOP_EN : when defined, an early release ramps V down to 0
//                       before the slot ends. The slot length limit does not
//                       apply to that ramp-down.
// ============================================================================
module motor_slot_scheduler #(
  parameter int SLOT_CYCLES = 16,
  parameter int RAMP_DIV    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] vel_alvo,
  output logic [1:0]  S,
  output logic [3:0]  V,
  output logic [3:0]  grant,
  output logic        ocupado,
  output logic        fim_slot
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RUN   = 2'd2,
    ST_END   = 2'd3
  } state_t;

  localparam logic [7:0] c_cnt_last  = 8'(SLOT_CYCLES - 1);
  localparam logic [7:0] c_ramp_last = 8'(RAMP_DIV - 1);

  state_t     state_q;
  logic [1:0] ptr_q;
  logic [1:0] win_q;
  logic [1:0] s_q;
  logic [3:0] v_q;
  logic [3:0] grant_q;
  logic       ocupado_q;
  logic       fim_q;
  logic [7:0] cnt_q;
  // The ramp phase runs separately from the slot counter. It stays periodic
  // even when a soft-stop ramp-down runs past the slot length.
  logic [7:0] phase_q;
  logic [3:0] cur_v_q [4];
`ifdef MOTOR_SOFTSTOP_EN
  logic       soft_q;
`endif

  logic [1:0] arb_ptr_d;
  logic [1:0] pick_d;
  logic       start_d;
  logic [3:0] load_v_d;
  logic       stop_d;
  logic [3:0] tgt_d;
  logic       tick_d;
  logic [7:0] phase_d;
  logic [3:0] v_ramp_d;

  // First set request bit, searching from base upward modulo 4.
  function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [3:0] r);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = base;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = base + 2'(k);
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    // In END the pointer update (winner+1) has not reached ptr_q yet.
    // Arbitration therefore uses the updated value directly.
    arb_ptr_d = (state_q == ST_END) ? (win_q + 2'd1) : ptr_q;
    pick_d    = rr_pick(arb_ptr_d, req);
    start_d   = ((state_q == ST_IDLE) || (state_q == ST_END)) && (|req);
    // Bypass the write-back that END performs in the same edge.
    load_v_d  = ((state_q == ST_END) && (pick_d == win_q)) ? v_q : cur_v_q[pick_d];

`ifdef MOTOR_SOFTSTOP_EN
    stop_d    = ~req[win_q] | soft_q;
`else
    stop_d    = ~req[win_q];
`endif

    tgt_d     = vel_alvo[{win_q, 2'b00} +: 4];
`ifdef MOTOR_SOFTSTOP_EN
    if (stop_d) begin
      tgt_d = 4'd0;
    end
`endif

    tick_d    = (phase_q == c_ramp_last);
    phase_d   = tick_d ? 8'd0 : (phase_q + 8'd1);

    // A single-LSB move toward the target cannot overshoot or wrap.
    v_ramp_d  = v_q;
    if (tick_d) begin
      if (v_q < tgt_d) begin
        v_ramp_d = v_q + 4'd1;
      end else if (v_q > tgt_d) begin
        v_ramp_d = v_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 2'd0;
      win_q     <= 2'd0;
      s_q       <= 2'd0;
      v_q       <= 4'd0;
      grant_q   <= 4'd0;
      ocupado_q <= 1'b0;
      fim_q     <= 1'b0;
      cnt_q     <= 8'd0;
      phase_q   <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        cur_v_q[i] <= 4'd0;
      end
`ifdef MOTOR_SOFTSTOP_EN
      soft_q    <= 1'b0;
`endif
    end else begin
      fim_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          v_q       <= 4'd0;
          grant_q   <= 4'd0;
          ocupado_q <= 1'b0;
        end
        ST_GRANT: begin
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (stop_d) begin
`ifdef MOTOR_SOFTSTOP_EN
            soft_q <= 1'b1;
            if (v_q == 4'd0) begin
              state_q <= ST_END;
              grant_q <= 4'd0;
              fim_q   <= 1'b1;
            end else begin
              v_q     <= v_ramp_d;
              phase_q <= phase_d;
              cnt_q   <= cnt_q + 8'd1;
            end
`else
            // Early release: V is frozen and the slot closes.
            state_q <= ST_END;
            grant_q <= 4'd0;
            fim_q   <= 1'b1;
`endif
          end else begin
            v_q     <= v_ramp_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_q + 8'd1;
            if (cnt_q == c_cnt_last) begin
              state_q <= ST_END;
              grant_q <= 4'd0;
              fim_q   <= 1'b1;
            end
          end
        end
        ST_END: begin
          cur_v_q[win_q] <= v_q;
          ptr_q          <= win_q + 2'd1;
          state_q        <= ST_IDLE;
          v_q            <= 4'd0;
          grant_q        <= 4'd0;
          ocupado_q      <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      // A new grant from IDLE or END overrides the defaults above.
      if (start_d) begin
        state_q   <= ST_GRANT;
        win_q     <= pick_d;
        s_q       <= pick_d;
        grant_q   <= 4'b0001 << pick_d;
        v_q       <= load_v_d;
        cnt_q     <= 8'd0;
        phase_q   <= 8'd0;
        ocupado_q <= 1'b1;
`ifdef MOTOR_SOFTSTOP_EN
        soft_q    <= 1'b0;
`endif
      end
    end
  end

  assign S        = s_q;
  assign V        = v_q;
  assign grant    = grant_q;
  assign ocupado  = ocupado_q;
  assign fim_slot = fim_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_slot_scheduler
// Description : Self-checking bench for motor_slot_scheduler. It has a
//               per-cycle reference model and a queue of expected outputs.
//               It also holds a hand-written vector table for the first
//               ramp scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_slot_scheduler;

  localparam int SLOT = 8;
  localparam int RDIV = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'd0;
  logic [15:0] vel_alvo = 16'd0;
  logic [1:0]  S;
  logic [3:0]  V;
  logic [3:0]  grant;
  logic        ocupado;
  logic        fim_slot;

  always #5 clk = ~clk;

  motor_slot_scheduler #(.SLOT_CYCLES(SLOT), .RAMP_DIV(RDIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .vel_alvo (vel_alvo),
    .S        (S),
    .V        (V),
    .grant    (grant),
    .ocupado  (ocupado),
    .fim_slot (fim_slot)
  );

  typedef struct packed {
    logic [1:0] s;
    logic [3:0] v;
    logic [3:0] g;
    logic       ocu;
    logic       fim;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] vel;
    exp_t        e;
  } vec_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state (0 idle, 1 grant, 2 run, 3 end)
  int         m_state, m_ptr, m_win, m_cnt, m_v;
  int         m_cur[4];
  logic [1:0] m_s;
  logic [3:0] m_g;
  logic       m_ocu, m_fim, m_soft;

  task automatic pop_check(input string tag);
    exp_t a, e;
    a = '{s: S, v: V, g: grant, ocu: ocupado, fim: fim_slot};
    n_checks++;
    if (sbq.size() == 0) begin
      $display("FAIL %s: no expected entry queued", tag);
    end else begin
      e = sbq.pop_front();
      if (a === e) n_pass++;
      else $display("FAIL %s: got S=%0d V=%0d grant=%b ocupado=%b fim_slot=%b, want S=%0d V=%0d grant=%b ocupado=%b fim_slot=%b",
                    tag, a.s, a.v, a.g, a.ocu, a.fim, e.s, e.v, e.g, e.ocu, e.fim);
    end
  endtask

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, act, exp);
  endtask

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_win = 0; m_cnt = 0; m_v = 0;
    for (int i = 0; i < 4; i++) m_cur[i] = 0;
    m_s = 2'd0; m_g = 4'd0; m_ocu = 1'b0; m_fim = 1'b0; m_soft = 1'b0;
  endtask

  task automatic model_push();
    sbq.push_back('{s: m_s, v: 4'(m_v), g: m_g, ocu: m_ocu, fim: m_fim});
  endtask

  task automatic model_start(input logic [3:0] rq);
    int w;
    w = -1;
    for (int k = 0; k < 4; k++) begin
      if (w < 0 && rq[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
    end
    m_win = w; m_state = 1; m_s = 2'(w); m_g = 4'(1 << w);
    m_v = m_cur[w]; m_cnt = 0; m_ocu = 1'b1; m_soft = 1'b0;
  endtask

  // Next-edge behaviour for the inputs that are being driven now.
  task automatic model_cycle(input logic [3:0] rq, input logic [15:0] va);
    int tgt;
    bit rel, tick, go_end;
    m_fim = 1'b0;
    case (m_state)
      0: begin
        if (rq != 4'd0) model_start(rq);
        else begin m_v = 0; m_g = 4'd0; m_ocu = 1'b0; end
      end
      1: m_state = 2;
      2: begin
        rel    = !rq[m_win];
        tgt    = int'((va >> (4 * m_win)) & 16'hF);
        tick   = ((m_cnt + 1) % RDIV) == 0;
        go_end = 1'b0;
`ifdef MOTOR_SOFTSTOP_EN
        if (rel || m_soft) begin
          m_soft = 1'b1;
          if (m_v == 0) go_end = 1'b1;
          else begin
            if (tick) m_v = m_v - 1;
            m_cnt++;
          end
        end else begin
          if (tick && m_v < tgt) m_v++;
          else if (tick && m_v > tgt) m_v--;
          if (m_cnt == SLOT - 1) go_end = 1'b1;
          m_cnt++;
        end
`else
        if (rel) go_end = 1'b1;
        else begin
          if (tick && m_v < tgt) m_v++;
          else if (tick && m_v > tgt) m_v--;
          if (m_cnt == SLOT - 1) go_end = 1'b1;
          m_cnt++;
        end
`endif
        if (go_end) begin m_state = 3; m_g = 4'd0; m_fim = 1'b1; end
      end
      default: begin
        m_cur[m_win] = m_v;
        m_ptr = (m_win + 1) % 4;
        if (rq != 4'd0) model_start(rq);
        else begin m_state = 0; m_v = 0; m_g = 4'd0; m_ocu = 1'b0; end
      end
    endcase
    model_push();
  endtask

  task automatic cycle(input logic [3:0] rq, input logic [15:0] va, input string tag);
    req = rq; vel_alvo = va;
    model_cycle(rq, va);
    @(posedge clk);
    @(negedge clk);
    pop_check(tag);
  endtask

  // Called at a negedge: asserts reset away from any clock edge.
  task automatic do_reset();
    rst = 1'b1; req = 4'd0; vel_alvo = 16'd0;
    model_reset();
    #1;
    model_push();
    pop_check("reset_async");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_push();
    pop_check("reset_state");
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic [15:0] va, input logic [1:0] s,
                              input logic [3:0] v, input logic [3:0] g, input logic o, input logic f);
    vec_t t;
    t.req = r; t.vel = va;
    t.e = '{s: s, v: v, g: g, ocu: o, fim: f};
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t      tab[21];
    int        gseq[$];
    int        rr_exp[5];
    logic [3:0] prevg;
    int        ocu_low;
    bit        found;

    // Motor 2, target F: two back-to-back slots, then release in END.
    tab[0]  = mk(4'b0100, 16'h0F00, 2, 0, 4'b0100, 1, 0);
    tab[1]  = mk(4'b0100, 16'h0F00, 2, 0, 4'b0100, 1, 0);
    tab[2]  = mk(4'b0100, 16'h0F00, 2, 0, 4'b0100, 1, 0);
    tab[3]  = mk(4'b0100, 16'h0F00, 2, 1, 4'b0100, 1, 0);
    tab[4]  = mk(4'b0100, 16'h0F00, 2, 1, 4'b0100, 1, 0);
    tab[5]  = mk(4'b0100, 16'h0F00, 2, 2, 4'b0100, 1, 0);
    tab[6]  = mk(4'b0100, 16'h0F00, 2, 2, 4'b0100, 1, 0);
    tab[7]  = mk(4'b0100, 16'h0F00, 2, 3, 4'b0100, 1, 0);
    tab[8]  = mk(4'b0100, 16'h0F00, 2, 3, 4'b0100, 1, 0);
    tab[9]  = mk(4'b0100, 16'h0F00, 2, 4, 4'b0000, 1, 1);
    tab[10] = mk(4'b0100, 16'h0F00, 2, 4, 4'b0100, 1, 0);
    tab[11] = mk(4'b0100, 16'h0F00, 2, 4, 4'b0100, 1, 0);
    tab[12] = mk(4'b0100, 16'h0F00, 2, 4, 4'b0100, 1, 0);
    tab[13] = mk(4'b0100, 16'h0F00, 2, 5, 4'b0100, 1, 0);
    tab[14] = mk(4'b0100, 16'h0F00, 2, 5, 4'b0100, 1, 0);
    tab[15] = mk(4'b0100, 16'h0F00, 2, 6, 4'b0100, 1, 0);
    tab[16] = mk(4'b0100, 16'h0F00, 2, 6, 4'b0100, 1, 0);
    tab[17] = mk(4'b0100, 16'h0F00, 2, 7, 4'b0100, 1, 0);
    tab[18] = mk(4'b0100, 16'h0F00, 2, 7, 4'b0100, 1, 0);
    tab[19] = mk(4'b0100, 16'h0F00, 2, 8, 4'b0000, 1, 1);
    tab[20] = mk(4'b0000, 16'h0F00, 2, 0, 4'b0000, 0, 0);
    rr_exp  = '{1, 2, 4, 8, 1};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 21; i++) begin
      req = tab[i].req; vel_alvo = tab[i].vel;
      sbq.push_back(tab[i].e);
      model_cycle(tab[i].req, tab[i].vel);
      @(posedge clk);
      @(negedge clk);
      pop_check($sformatf("tab%0d", i));
      pop_check($sformatf("tab%0d_model", i));
    end

    // Round-robin with all motors requesting.
    do_reset();
    prevg = 4'd0; ocu_low = 0;
    for (int i = 0; i < 48; i++) begin
      cycle(4'hF, 16'h9999, "rr");
      if (grant != 4'd0 && prevg == 4'd0) gseq.push_back(int'(grant));
      if (!ocupado) ocu_low++;
      prevg = grant;
    end
    for (int i = 0; i < 5; i++) chk($sformatf("rr_grant%0d", i), (i < gseq.size()) ? gseq[i] : -1, rr_exp[i]);
    chk("rr_ocupado_low_cycles", ocu_low, 0);

    // Motor 1 climbs to 6, then steps down to 3 and holds.
    do_reset();
    for (int i = 0; i < 20; i++) cycle(4'b0010, 16'h0060, "up6");
    for (int i = 0; i < 10; i++) cycle(4'b0010, 16'h0030, "down3");
    chk("down3_final_v", int'(V), 3);
    chk("down3_fim", int'(fim_slot), 1);

    // Async reset in the middle of RUN.
    do_reset();
    for (int i = 0; i < 15; i++) cycle(4'b0001, 16'h000F, "pre_rst");
    chk("v_before_reset", int'(V), 5);
    do_reset();
    cycle(4'b0001, 16'h000F, "regrant");
    chk("regrant_grant", int'(grant), 1);
    chk("regrant_v", int'(V), 0);

    // Early release of motor 3 at V=4.
    do_reset();
    for (int i = 0; i < 11; i++) cycle(4'b1000, 16'hF000, "m3_slot");
    chk("m3_grant_v", int'(V), 4);
    for (int i = 0; i < 14; i++) cycle(4'b0000, 16'hF000, "m3_release");
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      cycle(4'b1000, 16'hF000, "m3_again");
      if (grant == 4'b1000) found = 1'b1;
    end
    chk("m3_regrant_found", int'(found), 1);
`ifdef MOTOR_SOFTSTOP_EN
    chk("m3_resume_v", int'(V), 0);
`else
    chk("m3_resume_v", int'(V), 4);
`endif

    // Motor 0 target changes from 2 to 9 mid-slot.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(4'b0001, 16'h0002, "tgt2");
    for (int i = 0; i < 24; i++) cycle(4'b0001, 16'h0009, "tgt9");
    chk("tgt9_final_v", int'(V), 9);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cycle(4'($urandom_range(0, 15)), 16'($urandom), "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
